// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C memory slave.
//   ADDR_W / DATA_W : index and data widths of the first and second bytes
//   OP_READ         : value of the op bit (MSB of the first byte) that selects a read
//   slave_state_t   : top-level transaction states
//   ack_phase_t     : sub-steps of an ACK slot (drive, hold, release, branch)
package i2c_pkg;
    localparam int   ADDR_W  = 7;
    localparam int   DATA_W  = 8;
    localparam logic OP_READ = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RX_ADDR,
        ST_ACK_ADDR,
        ST_RX_DATA,
        ST_ACK_DATA,
        ST_TX_DATA,
        ST_RX_MACK,
        ST_WAIT_STOP
    } slave_state_t;

    typedef enum logic [1:0] {
        ACK_WAIT_FALL,
        ACK_WAIT_RISE,
        ACK_HOLD_CNT,
        ACK_WAIT_END
    } ack_phase_t;
endpackage

// File: rtl/i2c_bus_sync.sv
// Two-flop synchronizers for SCL/SDA plus bus event pulses.
// Ports:
//   clk, rst         : system clock, async active-low reset
//   i_scl, i_sda     : raw bus pins
//   o_sda            : synchronized SDA level (aligned with the edge pulses)
//   o_scl_rise/fall  : one-cycle SCL edge pulses
//   o_start/o_stop   : SDA fall/rise while SCL is high
// Stages reset to 1 so an idle (pulled-up) bus produces no edge after reset.
module i2c_bus_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start,
    output logic o_stop
);
    // [0] metastable stage, [1] synchronized, [2] previous synchronized value
    logic [2:0] r_scl;
    logic [2:0] r_sda;
    logic       w_scl_high;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scl <= 3'b111;
            r_sda <= 3'b111;
        end else begin
            r_scl <= {r_scl[1:0], i_scl};
            r_sda <= {r_sda[1:0], i_sda};
        end
    end

    assign w_scl_high = r_scl[1] & r_scl[2];
    assign o_sda      = r_sda[1];
    assign o_scl_rise = r_scl[1] & ~r_scl[2];
    assign o_scl_fall = ~r_scl[1] & r_scl[2];
    assign o_start    = w_scl_high & ~r_sda[1] & r_sda[2];
    assign o_stop     = w_scl_high & r_sda[1] & ~r_sda[2];
endmodule

// File: rtl/i2c_mem_slave.sv
// I2C target backed by a DEPTH x 8 register memory.
// Transaction: START, {op, addr[6:0]}, ACK, data byte, ACK, STOP (op=1 reads).
// Ports:
//   clk, rst   : system clock, async active-low reset (also clears memory)
//   scl, sda   : bus; sda is only ever driven low or released
//   busy       : START seen, transaction not yet back in IDLE
//   wr_stb     : one-cycle pulse when a write commits
//   rd_stb     : one-cycle pulse when the master ack of a read is sampled
//   last_addr  : memory index of the most recent access
//   last_data  : byte of the most recent access
// Build option: I2C_MEM_ADDR_CHECK_EN -- NACK addresses >= DEPTH instead of wrapping.
//
// state        | meaning
// IDLE         | waiting for START
// RX_ADDR      | shifting in {op, addr}
// ACK_ADDR     | driving/holding/releasing the address ACK
// RX_DATA      | shifting in the write byte
// ACK_DATA     | driving/holding/releasing the data ACK
// TX_DATA      | presenting the read byte, MSB first
// RX_MACK      | waiting for the master ack bit of a read
// WAIT_STOP    | waiting for a real STOP (self-induced rises filtered)
module i2c_mem_slave
    import i2c_pkg::*;
#(
    parameter int DEPTH    = 128,
    parameter int ACK_HOLD = 14,
    parameter int SETTLE   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scl,
    inout  wire               sda,
    output logic              busy,
    output logic              wr_stb,
    output logic              rd_stb,
    output logic [ADDR_W-1:0] last_addr,
    output logic [DATA_W-1:0] last_data
);
    localparam int         IDX_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0] HOLD_LOAD   = 8'(ACK_HOLD - 1);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE);

    logic w_sda, w_rise, w_fall, w_start, w_stop;

    i2c_bus_sync u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_scl      (scl),
        .i_sda      (sda),
        .o_sda      (w_sda),
        .o_scl_rise (w_rise),
        .o_scl_fall (w_fall),
        .o_start    (w_start),
        .o_stop     (w_stop)
    );

    slave_state_t      r_state, w_state_nx;
    ack_phase_t        r_phase, w_phase_nx;
    logic [2:0]        r_bit_cnt, w_bit_cnt_nx;
    logic [DATA_W-1:0] r_shift, w_shift_nx;
    logic              r_op, w_op_nx;
    logic [ADDR_W-1:0] r_addr, w_addr_nx;
    logic              r_sda_low, w_sda_low_nx;
    logic [7:0]        r_hold_cnt, w_hold_nx;
    logic [7:0]        r_settle_cnt;
    logic              r_busy, w_busy_nx;
    logic              r_wr_stb, w_wr_stb_nx;
    logic              r_rd_stb, w_rd_stb_nx;
    logic [ADDR_W-1:0] r_last_addr, w_last_addr_nx;
    logic [DATA_W-1:0] r_last_data, w_last_data_nx;
    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_mem_we, w_release, w_addr_ok;
    logic [DATA_W-1:0] w_wr_data, w_rd_byte;
    logic [IDX_W-1:0]  w_idx;

    assign w_idx     = r_addr[IDX_W-1:0];
    assign w_rd_byte = r_mem[w_idx];

`ifdef I2C_MEM_ADDR_CHECK_EN
    assign w_addr_ok = (int'(r_addr) < DEPTH);
`else
    assign w_addr_ok = 1'b1;
`endif

    always_comb begin
        w_state_nx     = r_state;
        w_phase_nx     = r_phase;
        w_bit_cnt_nx   = r_bit_cnt;
        w_shift_nx     = r_shift;
        w_op_nx        = r_op;
        w_addr_nx      = r_addr;
        w_sda_low_nx   = r_sda_low;
        w_hold_nx      = r_hold_cnt;
        w_busy_nx      = r_busy;
        w_wr_stb_nx    = 1'b0;
        w_rd_stb_nx    = 1'b0;
        w_last_addr_nx = r_last_addr;
        w_last_data_nx = r_last_data;
        w_mem_we       = 1'b0;
        w_wr_data      = {r_shift[DATA_W-2:0], w_sda};
        w_release      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nx   = ST_RX_ADDR;
                    w_bit_cnt_nx = 3'd0;
                    w_busy_nx    = 1'b1;
                end
            end
            ST_RX_ADDR, ST_RX_DATA: begin
                if (w_rise) begin
                    w_shift_nx   = {r_shift[DATA_W-2:0], w_sda};
                    w_bit_cnt_nx = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_phase_nx = ACK_WAIT_FALL;
                        if (r_state == ST_RX_ADDR) begin
                            w_op_nx    = r_shift[6];
                            w_addr_nx  = {r_shift[5:0], w_sda};
                            w_state_nx = ST_ACK_ADDR;
                        end else begin
                            w_mem_we       = 1'b1;
                            w_wr_stb_nx    = 1'b1;
                            w_last_addr_nx = ADDR_W'(w_idx);
                            w_last_data_nx = w_wr_data;
                            w_state_nx     = ST_ACK_DATA;
                        end
                    end
                end
            end
            ST_ACK_ADDR, ST_ACK_DATA: begin
                case (r_phase)
                    ACK_WAIT_FALL: if (w_fall) begin
                        // an out-of-range address gets a NACK: the slot runs but SDA stays released
                        w_sda_low_nx = (r_state == ST_ACK_DATA) || w_addr_ok;
                        w_phase_nx   = ACK_WAIT_RISE;
                    end
                    ACK_WAIT_RISE: if (w_rise) begin
                        w_hold_nx  = HOLD_LOAD;
                        w_phase_nx = ACK_HOLD_CNT;
                    end
                    ACK_HOLD_CNT: begin
                        if (r_hold_cnt == 8'd0) begin
                            // release while SCL is still high; the master may already be driving high
                            w_sda_low_nx = 1'b0;
                            w_release    = 1'b1;
                            if (r_state == ST_ACK_DATA || !w_addr_ok) w_state_nx = ST_WAIT_STOP;
                            else                                       w_phase_nx = ACK_WAIT_END;
                        end else begin
                            w_hold_nx = r_hold_cnt - 8'd1;
                        end
                    end
                    default: if (w_fall) begin
                        w_bit_cnt_nx = 3'd0;
                        if (r_op == OP_READ) begin
                            w_state_nx   = ST_TX_DATA;
                            w_sda_low_nx = ~w_rd_byte[DATA_W-1];
                            w_shift_nx   = {w_rd_byte[DATA_W-2:0], 1'b0};
                        end else begin
                            w_state_nx = ST_RX_DATA;
                        end
                    end
                endcase
            end
            ST_TX_DATA: begin
                if (w_fall) begin
                    if (r_bit_cnt == 3'd7) begin
                        w_sda_low_nx = 1'b0;
                        w_state_nx   = ST_RX_MACK;
                    end else begin
                        w_sda_low_nx = ~r_shift[DATA_W-1];
                        w_shift_nx   = {r_shift[DATA_W-2:0], 1'b0};
                        w_bit_cnt_nx = r_bit_cnt + 3'd1;
                    end
                end
            end
            ST_RX_MACK: begin
                if (w_rise) begin
                    w_rd_stb_nx    = 1'b1;
                    w_last_addr_nx = ADDR_W'(w_idx);
                    w_last_data_nx = w_rd_byte;
                    w_state_nx     = ST_WAIT_STOP;
                end
            end
            default: begin
                if (w_stop && r_settle_cnt == 8'd0) begin
                    w_state_nx = ST_IDLE;
                    w_busy_nx  = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_phase      <= ACK_WAIT_FALL;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_op         <= 1'b0;
            r_addr       <= '0;
            r_sda_low    <= 1'b0;
            r_hold_cnt   <= '0;
            r_settle_cnt <= '0;
            r_busy       <= 1'b0;
            r_wr_stb     <= 1'b0;
            r_rd_stb     <= 1'b0;
            r_last_addr  <= '0;
            r_last_data  <= '0;
        end else begin
            r_state      <= w_state_nx;
            r_phase      <= w_phase_nx;
            r_bit_cnt    <= w_bit_cnt_nx;
            r_shift      <= w_shift_nx;
            r_op         <= w_op_nx;
            r_addr       <= w_addr_nx;
            r_sda_low    <= w_sda_low_nx;
            r_hold_cnt   <= w_hold_nx;
            r_busy       <= w_busy_nx;
            r_wr_stb     <= w_wr_stb_nx;
            r_rd_stb     <= w_rd_stb_nx;
            r_last_addr  <= w_last_addr_nx;
            r_last_data  <= w_last_data_nx;
            // blanking window after each release hides our own SDA rise from STOP detection
            if (w_release)                r_settle_cnt <= SETTLE_LOAD;
            else if (r_settle_cnt != 8'd0) r_settle_cnt <= r_settle_cnt - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_mem_we) begin
            r_mem[w_idx] <= w_wr_data;
        end
    end

    assign sda       = r_sda_low ? 1'b0 : 1'bz;
    assign busy      = r_busy;
    assign wr_stb    = r_wr_stb;
    assign rd_stb    = r_rd_stb;
    assign last_addr = r_last_addr;
    assign last_data = r_last_data;
endmodule
